// File: rtl/lab3_pkg.sv
// rtl/lab3_pkg.sv - shared constants and select helper for the digit scan controller
package lab3_pkg;

    localparam int LAB3_NDIG     = 4;
    localparam int LAB3_DIV      = 4;
    localparam int LAB3_MAX_NDIG = 8;

    localparam logic [LAB3_MAX_NDIG-1:0] AN_OFF = '1;

    // Active-low one-hot select, sized for the widest supported display.
    function automatic logic [LAB3_MAX_NDIG-1:0] an_onehot_n(input logic [2:0] idx);
        return ~(LAB3_MAX_NDIG'(1) << idx);
    endfunction

endpackage

// File: rtl/lab3_tick_gen.sv
// rtl/lab3_tick_gen.sv - prescaler producing one tick every DIV clock cycles
module lab3_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int               CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Explicit compare so non-power-of-2 DIV values wrap correctly.
    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lab3_digit_scan.sv
// rtl/lab3_digit_scan.sv - double-buffered 7-segment digit scanner; LAB3_LEADING_ZERO_BLANK_EN enables leading-zero blanking
module lab3_digit_scan
    import lab3_pkg::*;
#(
    parameter int DIV  = LAB3_DIV,
    parameter int NDIG = LAB3_NDIG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    output logic              X3,
    output logic              X2,
    output logic              X1,
    output logic              X0,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int               IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NDIG - 1);

    logic              tick;
    logic              boundary;
    logic [IDX_W-1:0]  idx;
    logic [4*NDIG-1:0] disp;
    logic [4*NDIG-1:0] pend;
    logic              pv;
    logic [3:0]        nibble;
    logic [3:0]        nibble_q;
    logic [NDIG-1:0]   an_d;
    logic              blank;
`ifdef LAB3_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0]  hi;
`endif

    lab3_tick_gen #(
        .DIV   (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign boundary = tick && (idx == IDX_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
        end
    end

    // A load coinciding with the boundary bypasses pend so it costs no extra frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp <= '0;
            pend <= '0;
            pv   <= 1'b0;
        end else begin
            if (load) begin
                pend <= value;
            end
            if (boundary && load) begin
                disp <= value;
                pv   <= 1'b0;
            end else if (boundary && pv) begin
                disp <= pend;
                pv   <= 1'b0;
            end else if (load) begin
                pv   <= 1'b1;
            end
        end
    end

    always_comb begin
        nibble = disp[4*idx +: 4];
        an_d   = NDIG'(an_onehot_n(3'(idx)));
        blank  = 1'b0;
`ifdef LAB3_LEADING_ZERO_BLANK_EN
        hi = '0;
        for (int i = 1; i < NDIG; i++) begin
            if (disp[4*i +: 4] != 4'h0) begin
                hi = IDX_W'(i);
            end
        end
        blank = (idx > hi);
`endif
        if (blank) begin
            an_d = NDIG'(AN_OFF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nibble_q   <= 4'h0;
            an         <= NDIG'(AN_OFF);
            frame_done <= 1'b0;
        end else begin
            nibble_q   <= nibble;
            an         <= an_d;
            frame_done <= boundary;
        end
    end

    assign {X3, X2, X1, X0} = nibble_q;

endmodule

// File: tb/tb_lab3_digit_scan.sv
// tb/tb_lab3_digit_scan.sv - directed self-checking bench for lab3_digit_scan (DIV=4, NDIG=4)
`timescale 1ns/1ps
module tb_lab3_digit_scan;

    localparam int DIV  = 4;
    localparam int NDIG = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        X3, X2, X1, X0;
    logic [3:0]  an;
    logic        frame_done;
    logic [3:0]  nib;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign nib = {X3, X2, X1, X0};

    lab3_digit_scan #(
        .DIV        (DIV),
        .NDIG       (NDIG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .X3         (X3),
        .X2         (X2),
        .X1         (X1),
        .X0         (X0),
        .an         (an),
        .frame_done (frame_done)
    );

    function automatic logic [3:0] exp_an(input int d, input logic [15:0] v);
        logic [3:0] a;
`ifdef LAB3_LEADING_ZERO_BLANK_EN
        int hi;
`endif
        a = ~(4'b0001 << d);
`ifdef LAB3_LEADING_ZERO_BLANK_EN
        hi = 0;
        for (int i = 1; i < 4; i++) begin
            if (v[4*i +: 4] != 4'h0) hi = i;
        end
        if (d > hi) a = 4'hF;
`endif
        return a;
    endfunction

    task automatic pulse_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_frame_done(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout frame_done=0 required=1 within 40 cycles", tag);
        end
    endtask

    task automatic test_reset();
        load  = 1'b0;
        value = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (an !== 4'hF || nib !== 4'h0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold an=%b nib=%h fd=%b required an=1111 nib=0 fd=0", an, nib, frame_done);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (an !== exp_an((c/4) % 4, 16'h0000) || nib !== 4'h0 || frame_done !== 1'((c % 16) == 15)) begin
                errors++;
                $display("FAIL reset_scan c=%0d an=%b nib=%h fd=%b required an=%b nib=0 fd=%b",
                         c, an, nib, frame_done, exp_an((c/4) % 4, 16'h0000), 1'((c % 16) == 15));
            end
        end
    endtask

    task automatic test_load_midframe();
        logic [15:0] v;
        bit seen;
        v = 16'h1A2F;
        pulse_load(v);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (nib !== 4'h0) begin
                errors++;
                $display("FAIL midframe_old nib=%h required=0", nib);
            end
            if (frame_done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL midframe_timeout frame_done=0 required=1");
        end
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (an !== exp_an(c/4, v) || nib !== v[4*(c/4) +: 4] || frame_done !== 1'(c == 15)) begin
                errors++;
                $display("FAIL midframe_new c=%0d an=%b nib=%h fd=%b required an=%b nib=%h fd=%b",
                         c, an, nib, frame_done, exp_an(c/4, v), v[4*(c/4) +: 4], 1'(c == 15));
            end
        end
    endtask

    task automatic test_double_load();
        logic [15:0] v;
        v = 16'h2222;
        pulse_load(16'h1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        pulse_load(v);
        wait_frame_done("double_load");
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (an !== exp_an(c/4, v) || nib !== 4'h2 || frame_done !== 1'(c == 15)) begin
                errors++;
                $display("FAIL double_load c=%0d an=%b nib=%h fd=%b required an=%b nib=2 fd=%b",
                         c, an, nib, frame_done, exp_an(c/4, v), 1'(c == 15));
            end
        end
    endtask

    task automatic test_load_at_boundary();
        logic [15:0] v;
        v = 16'h3456;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (nib !== 4'h2) begin
                errors++;
                $display("FAIL boundary_pre c=%0d nib=%h required=2", c, nib);
            end
        end
        load  = 1'b1;
        value = v;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL boundary_edge fd=%b required=1", frame_done);
        end
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (an !== exp_an(c/4, v) || nib !== v[4*(c/4) +: 4] || frame_done !== 1'(c == 15)) begin
                errors++;
                $display("FAIL boundary_load c=%0d an=%b nib=%h fd=%b required an=%b nib=%h fd=%b",
                         c, an, nib, frame_done, exp_an(c/4, v), v[4*(c/4) +: 4], 1'(c == 15));
            end
        end
    endtask

    task automatic test_async_reset();
        pulse_load(16'h9999);
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (an !== exp_an(2, 16'h3456) || nib !== 4'h4) begin
            errors++;
            $display("FAIL async_pre an=%b nib=%h required an=%b nib=4", an, nib, exp_an(2, 16'h3456));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || nib !== 4'h0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL async_blank an=%b nib=%h fd=%b required an=1111 nib=0 fd=0", an, nib, frame_done);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (an !== exp_an((c/4) % 4, 16'h0000) || nib !== 4'h0 || frame_done !== 1'((c % 16) == 15)) begin
                errors++;
                $display("FAIL async_restart c=%0d an=%b nib=%h fd=%b required an=%b nib=0 fd=%b",
                         c, an, nib, frame_done, exp_an((c/4) % 4, 16'h0000), 1'((c % 16) == 15));
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] v;
        v = 16'h0070;
        pulse_load(v);
        wait_frame_done("lzb_0070");
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (an !== exp_an(c/4, v) || nib !== v[4*(c/4) +: 4] || frame_done !== 1'(c == 15)) begin
                errors++;
                $display("FAIL lzb_0070 c=%0d an=%b nib=%h fd=%b required an=%b nib=%h fd=%b",
                         c, an, nib, frame_done, exp_an(c/4, v), v[4*(c/4) +: 4], 1'(c == 15));
            end
        end
        v = 16'h0000;
        pulse_load(v);
        wait_frame_done("lzb_0000");
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (an !== exp_an(c/4, v) || nib !== 4'h0 || frame_done !== 1'(c == 15)) begin
                errors++;
                $display("FAIL lzb_0000 c=%0d an=%b nib=%h fd=%b required an=%b nib=0 fd=%b",
                         c, an, nib, frame_done, exp_an(c/4, v), 1'(c == 15));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_midframe();
        test_double_load();
        test_load_at_boundary();
        test_async_reset();
        test_leading_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab3_digit_scan.md
# lab3_digit_scan

Time-multiplexed scan controller sitting directly upstream of the 7-segment decoder. Holds an NDIG-digit hex value, cycles through its digits at a fixed rate, and drives the current 4-bit nibble to the decoder's X3..X0 inputs together with active-low digit-select (anode) lines. New values are double-buffered and applied only on a frame boundary, so a displayed frame never mixes old and new digits.

## Interface
- DIV, 4: clock cycles each digit stays selected; legal range 2..65535
- NDIG, 4: number of digits scanned; legal range 1..8
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  single-cycle strobe; captures value into the pending buffer
- value  in  4*NDIG  hex digits; digit 0 = value[3:0]
- X3, X2, X1, X0  out  1 each  nibble of the selected digit, MSB first; connects straight to the decoder inputs
- an  out  NDIG  active-low digit selects; at most one bit low
- frame_done  out  1  one-cycle pulse on the last cycle of each frame

## Operation
- State: prescaler cnt (0..DIV-1), digit index idx (0..NDIG-1), display register disp, pending register pend, pending flag pv.
- cnt increments every cycle and wraps at DIV-1. The wrap cycle is the tick.
- On a tick, idx increments and wraps NDIG-1 -> 0. A tick with idx == NDIG-1 is the frame boundary.
- load: pend <= value and pv <= 1. A second load before the boundary overwrites pend; the last value wins.
- Frame boundary: if pv is set, disp <= pend and pv <= 0.
- load in the same cycle as a frame boundary: value goes directly into disp and pv ends at 0.
- Outputs are registered each cycle from the current state:
  - {X3,X2,X1,X0} <= disp[4*idx +: 4]
  - an <= ~(1 << idx)
  - frame_done <= frame boundary.
- No arithmetic beyond the counters. cnt is $clog2(DIV) bits and idx is $clog2(NDIG) bits (minimum 1 bit). Wrap is an explicit compare, not a power-of-2 overflow.

## Timing
- Reset (asynchronous, while rst_n = 0) sets the following. Nothing is latched while rst_n is low.
  - cnt = 0, idx = 0, disp = 0, pend = 0, pv = 0
  - X3..X0 = 0, an = all ones (all digits off), frame_done = 0
- First rising edge after rst_n goes high: an = ...1110 and nibble = disp[3:0].
- Each digit is selected for exactly DIV cycles. A frame is NDIG*DIV cycles.
- Output latency from a state change is 1 cycle.
- frame_done goes high in the cycle where an moves from digit NDIG-1 to digit 0.
- A loaded value becomes visible on the first digit-0 slot after the next frame boundary. Worst case this is NDIG*DIV + 1 cycles after load.
- Reset asserted mid-frame blanks the display immediately (an all ones) and discards pend.

## Configuration
- LAB3_LEADING_ZERO_BLANK_EN defined: a digit whose index is above the highest nonzero digit of disp has its an bit forced high during its slot.
  - Digit 0 is never blanked, so 0 displays as a single "0".
  - Slot timing and frame_done are unchanged.
- LAB3_LEADING_ZERO_BLANK_EN undefined: all NDIG digits are always shown, including leading zeros.

## Structure
- Package lab3_pkg holds:
  - default constants LAB3_NDIG = 4 and LAB3_DIV
  - function an_onehot_n(idx) returning the active-low select
  - constant AN_OFF (all ones)
- Sub-module lab3_tick_gen (parameter DIV; ports clk, rst_n, tick) contains the prescaler. The scan logic stays in lab3_digit_scan.

## Test plan
All scenarios use DIV=4, NDIG=4.
- Reset: hold rst_n=0 -> an=4'b1111, X3..X0=0, frame_done=0. Release -> an=1110 after 1 edge and stays 4 cycles, then 1101, 1011, 0111, then back to 1110.
- Load 16'h1A2F mid-frame -> current frame still shows 0. After frame_done, slots show F, 2, A, 1 on an = 1110, 1101, 1011, 0111.
- Two loads in one frame (16'h1111 then 16'h2222) -> the next frame shows only 2.
- Load 16'h3456 in the same cycle as the frame boundary -> the next digit-0 slot shows 6, with no extra frame of delay.
- Assert rst_n=0 during the digit-2 slot -> an=1111 asynchronously, with no clock needed. After release, disp=0 and scanning restarts at digit 0.
- With LAB3_LEADING_ZERO_BLANK_EN, load 16'h0070 -> digits 3 and 2 have an held high, digit 1 shows 7, digit 0 shows 0. Load 16'h0000 -> only digit 0 lights, showing 0.
